audiodac_sinegen_mc: RTL and testbench
======================================

// Module: audiodac_sinegen_mc
//
// PURPOSE
// Multi-channel test-tone generator; parametrised successor to the single-channel audiodac sine generator.
// A shared phase accumulator feeds NCH channels, each offset by a fixed phase, through one time-multiplexed
// quarter-wave ROM, with per-block amplitude attenuation. Sits in front of the delta-sigma modulator(s)
// and is muxed in place of the audio input when tst_sinegen_en=1; one sample set per data_rd_i strobe.
//
// PARAMETERS
// NCH        2      number of output channels (1..8)
// DATA_W     16     sample width, two's complement
// LUT_AW     6      quarter-wave ROM address bits (2^LUT_AW entries)
// PHASE_W    10     accumulator width; >= LUT_AW+2, low PHASE_W-LUT_AW-2 bits are truncated fraction
// STEP_W     4      phase step input width
// CH_PH_OFS  2**(PHASE_W-2)  phase offset between adjacent channels (default 90 deg)
//
// PORTS
// clk_i             in   1            system clock
// rst_n_i           in   1            asynchronous active-low reset
// data_rd_i         in   1            sample request strobe, one cycle per request
// tst_sinegen_en    in   1            generator enable
// tst_sinegen_step  in   STEP_W       phase increment per request, unsigned
// tst_sinegen_atten in   3            attenuation, arithmetic right shift 0..7 (6 dB steps)
// data_o            out  NCH*DATA_W   channel k in bits [k*DATA_W +: DATA_W]
// data_valid_o      out  1            one-cycle pulse: full new sample set on data_o
// busy_o            out  1            computation in progress
//
// BEHAVIOUR
// - Reset: data_o=0, data_valid_o=0, busy_o=0, acc=0, pending=0, FSM=IDLE.
// - FSM IDLE -> CALC on data_rd_i (or on pending); CALC steps channel index ch=0..NCH-1, one channel per cycle;
//   after ch=NCH-1 -> DONE (1 cycle: data_o updated atomically, data_valid_o=1) -> IDLE.
//   Latency: strobe at cycle t -> data_valid_o at cycle t+NCH+1. busy_o=1 in CALC and DONE.
// - Step, atten and acc are sampled when entering CALC; step/atten changes mid-CALC take effect next request.
// - Channel phase p_k = acc + k*CH_PH_OFS (mod 2^PHASE_W). On DONE: acc <= acc + step (wraps mod 2^PHASE_W).
//   The first set after enable therefore uses acc=0.
// - Quarter-wave decode: q=p[PHASE_W-1:PHASE_W-2], a=p[PHASE_W-3 -: LUT_AW]; address = q[0] ? ~a : a;
//   value negated when q[1]=1. ROM[i] = round((2^(DATA_W-1)-1)*sin(pi/2*(i+0.5)/2^LUT_AW)), never 0,
//   so negation cannot overflow. Sample = value >>> atten (sign-preserving).
// - data_rd_i while busy_o=1: sets one-deep pending flag; further strobes while pending=1 are dropped.
//   Pending request is served immediately after DONE (IDLE for 0 cycles).
// - tst_sinegen_en=0: acc and pending cleared; any CALC aborted to IDLE without data_valid_o; data_o forced 0
//   next cycle; strobes ignored. Enable rising edge: no output change until the next strobe.
// - Strobe coincident with enable falling: ignored. Async reset mid-CALC: all state to reset values.
//
// STRUCTURE
// - Shared package audiodac_pkg: sample type width, ROM depth constant, FSM state encoding (IDLE/CALC/DONE).
// - Sub-module audiodac_sinegen_rom: combinational quarter-wave ROM, LUT_AW in, DATA_W-1 out, table generated
//   at elaboration from the ROM[i] formula; top level holds FSM, accumulator, mirror/negate, shift, output regs.
//
// TESTING
// - Reset then en=1, step=1, atten=0, one strobe -> valid after NCH+1=3 cycles; ch0=402, ch1=32765.
// - Strobe again -> ch0 phase 1 (frac) still addr 0 -> 402; after 4 strobes (step=1) ch0 uses addr 1 -> 1206.
// - step=15, 1024 strobes -> acc wraps to 15*1024 mod 1024 = 0; ch0 sign follows quadrant sequence,
//   min=-32765, max=+32765.
// - atten=3 at phase 0 -> ch0=402>>>3=50, ch1=32765>>>3=4095; at q=2, ch0=-402>>>3=-51.
// - Two strobes back-to-back, third during busy -> exactly two valid pulses, second at t+2*(NCH+1).
// - en dropped mid-CALC -> no valid pulse, data_o=0 next cycle; re-enable + strobe -> ch0=402 (acc restarted).

Source files
------------

// File: rtl/audiodac_pkg.sv
// ============================================================================
// Module : audiodac_pkg
// Brief  : Shared types, constants and ROM-table helper for the audiodac
//          multi-channel sine generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package audiodac_pkg;

    localparam int c_DATA_W    = 16;
    localparam int c_LUT_AW    = 6;
    localparam int c_ROM_DEPTH = 2 ** c_LUT_AW;
    localparam real c_PI       = 3.14159265358979323846;

    typedef logic signed [c_DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_CALC = 2'd1,
        c_ST_DONE = 2'd2
    } state_t;

    // Sampling at bin centres keeps every entry non-zero, so negation never overflows.
    function automatic int rom_value(input int idx, input int data_w, input int lut_aw);
        real amp;
        real s;
        amp = (2.0 ** (data_w - 1)) - 1.0;
        s   = $sin(c_PI / 2.0 * (real'(idx) + 0.5) / real'(2 ** lut_aw));
        return $rtoi(amp * s + 0.5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/audiodac_sinegen_rom.sv
// ============================================================================
// Module : audiodac_sinegen_rom
// Brief  : Combinational quarter-wave sine magnitude ROM, built at elaboration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module audiodac_sinegen_rom
    import audiodac_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int LUT_AW = c_LUT_AW
) (
    input  logic [LUT_AW-1:0] i_addr,
    output logic [DATA_W-2:0] o_mag
);

    logic [DATA_W-2:0] w_rom [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam int c_VAL = rom_value(i, DATA_W, LUT_AW);
        assign w_rom[i] = (DATA_W-1)'(c_VAL);
    end

    assign o_mag = w_rom[i_addr];

endmodule

`default_nettype wire

// File: rtl/audiodac_sinegen_mc.sv
// ============================================================================
// Module : audiodac_sinegen_mc
// Brief  : Multi-channel test-tone generator: shared phase accumulator, one
//          time-multiplexed quarter-wave ROM, per-block attenuation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module audiodac_sinegen_mc
    import audiodac_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int DATA_W    = c_DATA_W,
    parameter int LUT_AW    = c_LUT_AW,
    parameter int PHASE_W   = 10,
    parameter int STEP_W    = 4,
    parameter int CH_PH_OFS = 2 ** (PHASE_W - 2)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    data_rd_i,
    input  logic                    tst_sinegen_en,
    input  logic [STEP_W-1:0]       tst_sinegen_step,
    input  logic [2:0]              tst_sinegen_atten,
    output logic [NCH*DATA_W-1:0]   data_o,
    output logic                    data_valid_o,
    output logic                    busy_o
);

    localparam int c_CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CH_W-1:0]         r_ch;
    logic [PHASE_W-1:0]        r_acc;
    logic [PHASE_W-1:0]        r_ph;
    logic [STEP_W-1:0]         r_step;
    logic [2:0]                r_atten;
    logic                      r_pend;
    logic signed [DATA_W-1:0]  r_stage [NCH];
    logic [NCH*DATA_W-1:0]     r_data;

    logic                      w_req;
    logic                      w_last;
    logic                      w_start;
    logic [PHASE_W-1:0]        w_acc_upd;
    logic [1:0]                w_q;
    logic [LUT_AW-1:0]         w_a;
    logic [LUT_AW-1:0]         w_addr;
    logic [DATA_W-2:0]         w_mag;
    logic signed [DATA_W-1:0]  w_pos;
    logic signed [DATA_W-1:0]  w_val;
    logic signed [DATA_W-1:0]  w_sample;
    logic [NCH*DATA_W-1:0]     w_next_data;

    assign w_req     = r_pend | data_rd_i;
    assign w_last    = (r_ch == c_CH_W'(NCH - 1));
    assign w_start   = (w_state_nxt == c_ST_CALC) && (r_state != c_ST_CALC);
    assign w_acc_upd = r_acc + PHASE_W'(r_step);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!tst_sinegen_en) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (w_req) w_state_nxt = c_ST_CALC;
                c_ST_CALC: if (w_last) w_state_nxt = c_ST_DONE;
                // A queued request restarts straight from DONE with no idle gap.
                c_ST_DONE: w_state_nxt = w_req ? c_ST_CALC : c_ST_IDLE;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_valid_o = (r_state == c_ST_DONE);
        busy_o       = (r_state != c_ST_IDLE);
    end

    // Quadrant mirror/negate around the quarter-wave table; fraction bits drop out in the shift.
    assign w_q    = r_ph[PHASE_W-1 -: 2];
    assign w_a    = LUT_AW'(r_ph >> (PHASE_W - 2 - LUT_AW));
    assign w_addr = w_q[0] ? ~w_a : w_a;

    audiodac_sinegen_rom #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .i_addr (w_addr),
        .o_mag  (w_mag)
    );

    assign w_pos    = {1'b0, w_mag};
    assign w_val    = w_q[1] ? -w_pos : w_pos;
    assign w_sample = w_val >>> r_atten;

    // Last channel bypasses staging so the whole set lands in data_o on the same edge.
    for (genvar k = 0; k < NCH; k++) begin : g_pack
        if (k == NCH - 1) begin : g_last
            assign w_next_data[k*DATA_W +: DATA_W] = w_sample;
        end else begin : g_staged
            assign w_next_data[k*DATA_W +: DATA_W] = r_stage[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ch    <= '0;
            r_acc   <= '0;
            r_ph    <= '0;
            r_step  <= '0;
            r_atten <= '0;
            r_pend  <= 1'b0;
            r_data  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (!tst_sinegen_en) begin
            r_ch   <= '0;
            r_acc  <= '0;
            r_pend <= 1'b0;
            r_data <= '0;
        end else begin
            if (r_state == c_ST_DONE) begin
                r_acc <= w_acc_upd;
            end
            if (w_start) begin
                r_ph    <= (r_state == c_ST_DONE) ? w_acc_upd : r_acc;
                r_step  <= tst_sinegen_step;
                r_atten <= tst_sinegen_atten;
                r_ch    <= '0;
                r_pend  <= 1'b0;
            end else if (r_state == c_ST_CALC) begin
                r_ph          <= r_ph + PHASE_W'(CH_PH_OFS);
                r_ch          <= r_ch + c_CH_W'(1);
                r_stage[r_ch] <= w_sample;
                if (data_rd_i) begin
                    r_pend <= 1'b1;
                end
                if (w_last) begin
                    r_data <= w_next_data;
                end
            end
        end
    end

    assign data_o = r_data;

endmodule

`default_nettype wire

// File: tb/tb_audiodac_sinegen_mc.sv
// ============================================================================
// Module : tb_audiodac_sinegen_mc
// Brief  : Self-checking bench for audiodac_sinegen_mc against an arithmetic
//          sine model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audiodac_sinegen_mc;

    localparam int NCH    = 2;
    localparam int DATA_W = 16;
    localparam int PH_MOD = 1024;
    localparam int OFS    = 256;
    localparam real PI    = 3.14159265358979323846;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i = 1'b0;
    logic                  data_rd_i = 1'b0;
    logic                  tst_sinegen_en = 1'b0;
    logic [3:0]            tst_sinegen_step = '0;
    logic [2:0]            tst_sinegen_atten = '0;
    logic [NCH*DATA_W-1:0] data_o;
    logic                  data_valid_o;
    logic                  busy_o;

    int checks = 0;
    int errors = 0;
    int m_acc  = 0;

    audiodac_sinegen_mc #(
        .NCH (NCH)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .data_rd_i         (data_rd_i),
        .tst_sinegen_en    (tst_sinegen_en),
        .tst_sinegen_step  (tst_sinegen_step),
        .tst_sinegen_atten (tst_sinegen_atten),
        .data_o            (data_o),
        .data_valid_o      (data_valid_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Ideal sine sampled at the centre of its quarter-wave bin, then floor-divided by 2^atten.
    function automatic int ref_sample(input int acc, input int k, input int atten);
        int p, quad, idx, mag, v;
        p    = (acc + k * OFS) % PH_MOD;
        quad = p / 256;
        idx  = (p % 256) / 4;
        if (quad % 2 == 1) idx = 63 - idx;
        mag  = $rtoi(32767.0 * $sin(PI / 2.0 * (real'(idx) + 0.5) / 64.0) + 0.5);
        v    = (quad >= 2) ? -mag : mag;
        return $rtoi($floor(real'(v) / real'(1 << atten)));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int chan(input int k);
        logic signed [DATA_W-1:0] s;
        s = data_o[k*DATA_W +: DATA_W];
        return int'(s);
    endfunction

    task automatic strobe_wait(input string tag);
        int lat;
        lat = 0;
        data_rd_i = 1'b1;
        do begin
            tick();
            lat++;
            data_rd_i = 1'b0;
        end while (!data_valid_o && lat < 20);
        check({tag, "_lat"}, lat, NCH + 1);
    endtask

    task automatic check_set(input string tag, input int atten, input int step);
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("%s_ch%0d", tag, k), chan(k), ref_sample(m_acc, k, atten));
        end
        m_acc = (m_acc + step) % PH_MOD;
    endtask

    initial begin
        int st, at, mn, mx, npulse, p1, p2;
        int snap [2][NCH];

        // Reset state
        #12;
        check("rst_data", int'(data_o != '0), 0);
        check("rst_valid", int'(data_valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        tick();
        rst_n_i = 1'b1;
        tick();

        // First set after enable, step 1, no attenuation
        tst_sinegen_en = 1'b1;
        tst_sinegen_step = 4'd1;
        tst_sinegen_atten = 3'd0;
        tick();
        check("en_no_change", int'(data_o != '0), 0);
        strobe_wait("first");
        check("first_ch0", chan(0), 402);
        check("first_ch1", chan(1), 32765);
        check_set("first", 0, 1);
        tick();
        check("valid_one_cycle", int'(data_valid_o), 0);
        check("idle_after", int'(busy_o), 0);

        for (int n = 0; n < 4; n++) begin
            strobe_wait("step1");
            if (n < 3) check("frac_ch0", chan(0), 402);
            else       check("addr1_ch0", chan(0), 1206);
            check_set("step1", 0, 1);
            tick();
        end

        // Random step/atten with random idle gaps
        for (int n = 0; n < 120; n++) begin
            st = $urandom_range(0, 15);
            at = $urandom_range(0, 7);
            tst_sinegen_step = 4'(st);
            tst_sinegen_atten = 3'(at);
            repeat ($urandom_range(0, 3)) tick();
            strobe_wait("rnd");
            check_set("rnd", at, st);
            tick();
        end

        // Restart accumulator, then full-scale sweep with step 15
        tst_sinegen_en = 1'b0;
        tick();
        tst_sinegen_en = 1'b1;
        m_acc = 0;
        tst_sinegen_step = 4'd15;
        tst_sinegen_atten = 3'd0;
        mn = 0;
        mx = 0;
        for (int n = 0; n < 1024; n++) begin
            strobe_wait("sweep");
            if (chan(0) < mn) mn = chan(0);
            if (chan(0) > mx) mx = chan(0);
            check_set("sweep", 0, 15);
        end
        check("sweep_min", mn, -32765);
        check("sweep_max", mx, 32765);
        tick();
        strobe_wait("wrap");
        check("wrap_ch0", chan(0), 402);
        check_set("wrap", 0, 15);
        tick();

        // Attenuation by 3 at phase 0 and at the negative half
        tst_sinegen_en = 1'b0;
        tick();
        tst_sinegen_en = 1'b1;
        m_acc = 0;
        tst_sinegen_step = 4'd8;
        tst_sinegen_atten = 3'd3;
        strobe_wait("att0");
        check("att0_ch0", chan(0), 50);
        check("att0_ch1", chan(1), 4095);
        check_set("att0", 3, 8);
        for (int n = 0; n < 63; n++) begin
            strobe_wait("att");
            check_set("att", 3, 8);
        end
        strobe_wait("att512");
        check("att512_ch0", chan(0), -51);
        check_set("att512", 3, 8);
        tick();

        // Back-to-back strobes plus a third while pending is already set
        st = $urandom_range(1, 15);
        at = $urandom_range(0, 7);
        tst_sinegen_step = 4'(st);
        tst_sinegen_atten = 3'(at);
        npulse = 0;
        p1 = 0;
        p2 = 0;
        for (int c = 1; c <= 20; c++) begin
            data_rd_i = (c <= 3);
            tick();
            if (data_valid_o) begin
                if (npulse == 0) p1 = c;
                if (npulse == 1) p2 = c;
                if (npulse < 2)
                    for (int k = 0; k < NCH; k++) snap[npulse][k] = chan(k);
                npulse++;
            end
        end
        data_rd_i = 1'b0;
        check("b2b_pulses", npulse, 2);
        check("b2b_first", p1, NCH + 1);
        check("b2b_second", p2, 2 * (NCH + 1));
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NCH; k++)
                check($sformatf("b2b%0d_ch%0d", s, k), snap[s][k], ref_sample(m_acc, k, at));
            m_acc = (m_acc + st) % PH_MOD;
        end

        // Enable dropped mid-CALC aborts without a pulse
        data_rd_i = 1'b1;
        tick();
        data_rd_i = 1'b0;
        tst_sinegen_en = 1'b0;
        tick();
        check("abort_data", int'(data_o != '0), 0);
        check("abort_busy", int'(busy_o), 0);
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (data_valid_o) npulse++;
        end
        check("abort_pulses", npulse, 0);
        tst_sinegen_en = 1'b1;
        m_acc = 0;
        tst_sinegen_step = 4'd1;
        tst_sinegen_atten = 3'd0;
        tick();
        check("reen_quiet", int'(data_o != '0), 0);
        strobe_wait("reen");
        check("reen_ch0", chan(0), 402);
        check_set("reen", 0, 1);
        tick();

        // Strobe coincident with enable falling is ignored
        tst_sinegen_en = 1'b0;
        data_rd_i = 1'b1;
        tick();
        data_rd_i = 1'b0;
        check("coinc_busy", int'(busy_o), 0);
        tst_sinegen_en = 1'b1;
        m_acc = 0;
        tick();
        check("coinc_busy2", int'(busy_o), 0);

        // Asynchronous reset in the middle of CALC
        data_rd_i = 1'b1;
        tick();
        data_rd_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_busy", int'(busy_o), 0);
        check("arst_data", int'(data_o != '0), 0);
        tick();
        rst_n_i = 1'b1;
        m_acc = 0;
        tick();
        check("arst_valid", int'(data_valid_o), 0);
        strobe_wait("post_rst");
        check("post_rst_ch0", chan(0), 402);
        check_set("post_rst", 0, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
